rca_pipe_addsub: RTL
====================

Name: rca_pipe_addsub

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor; successor to the 8-bit combinational RCA.
- Splits a WIDTH-bit add into STAGES ripple slices with registered inter-slice carries. Accepts one operation per cycle under a valid/ready handshake.
- Provides carry-out and signed-overflow flags.
- Used as the datapath adder wherever WIDTH > 8 or timing requires a pipelined carry chain.

Parameters:
- WIDTH, 8, operand/result width in bits; must be >= 1.
- STAGES, 2, pipeline depth and slice count. WIDTH % STAGES == 0 is required; the compile-time check fails otherwise.
- SLICE, WIDTH/STAGES, derived localparam; ripple width per stage.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, operation present on A/B/C/SUB.
- in_ready, output, 1, block can accept an operation this cycle.
- A, input, WIDTH, operand A.
- B, input, WIDTH, operand B.
- C, input, 1, carry-in (add) / borrow-in (sub).
- SUB, input, 1, 0 = add, 1 = subtract.
- out_valid, output, 1, result present on S/cout/ovf.
- out_ready, input, 1, downstream accepts result.
- S, output, WIDTH, sum/difference.
- cout, output, 1, raw carry out of the MSB slice.
- ovf, output, 1, two's-complement signed overflow.

Behaviour:
- Reset (rst=1 at a rising edge):
  - All pipeline valid bits, S, cout and ovf clear to 0.
  - in_ready=1 in the cycle after reset.
  - Reset mid-operation discards all in-flight operations; no partial result is ever presented.
- Arithmetic:
  - Effective B' = SUB ? ~B : B; effective cin = SUB ? ~C : C.
  - Add: S = A + B + C. Sub: S = A - B - C.
  - cout = carry out of bit WIDTH-1 of A + B' + cin. When SUB=1, cout=1 means no borrow.
  - ovf = (A[W-1] == B'[W-1]) && (S[W-1] != A[W-1]).
  - All results are modulo 2^WIDTH.
- Pipeline:
  - Stage k (0..STAGES-1) ripples bits [k*SLICE +: SLICE] using the carry registered from stage k-1; stage 0 uses cin.
  - Upper operand slices are carried forward in skew registers; lower result slices are carried forward in deskew registers, so all result bits emerge aligned.
  - Latency: an operation accepted at edge N appears on out_valid/S at edge N+STAGES, assuming no stall.
  - Throughput: 1 op/cycle.
- Handshake:
  - Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
  - stall = out_valid && !out_ready. The whole pipeline freezes on stall.
  - in_ready = !stall (combinational from out_ready).
  - While stalled, S/cout/ovf/out_valid hold stable.
  - Bubbles (in_valid=0) propagate as invalid stages; there is no bubble compression.
  - out_valid is never asserted for a cycle without a corresponding accepted input.
- Boundaries:
  - STAGES=1 gives one registered output stage (latency 1).
  - STAGES=WIDTH gives a 1-bit slice per stage.
  - Simultaneous output transfer and input acceptance in the same cycle is legal and required for full throughput.
  - A, B, C and SUB are sampled only on an input transfer; they are don't-care otherwise.

Test Plan:
- Add, WIDTH=8, STAGES=2: A=8'h8B, B=8'h71, C=0, SUB=0 -> after 2 cycles S=8'hFC, cout=0, ovf=0.
- Subtract and signed overflow, WIDTH=8:
  - A=8'h8B, B=8'h71, C=0, SUB=1 -> S=8'h1A, cout=1, ovf=1 (-117-113 overflows).
  - Then A=8'h7F, B=8'h01, C=0, SUB=0 -> S=8'h80, cout=0, ovf=1.
  - Then A=8'hFF, B=8'h00, C=1, SUB=0 -> S=8'h00, cout=1, ovf=0.
- Throughput, WIDTH=32, STAGES=4, out_ready=1: 100 back-to-back random ops -> 100 results in order, first at cycle 4, one per cycle thereafter, each matching the reference model A+B+C or A-B-C mod 2^32.
- Backpressure: stream 10 ops; drop out_ready for 3 cycles at op 5 -> in_ready=0 during the stall, S held stable, no loss or duplication, order preserved.
- Reset mid-operation: accept 2 ops, assert rst for 1 cycle before either emerges -> out_valid stays 0 and both ops never appear; the next op issued after reset returns correctly with latency STAGES.
- Corner parameters: STAGES=1 and STAGES=WIDTH=8 with A=8'hFF, B=8'h01, C=0 -> S=8'h00, cout=1, ovf=0 at latency 1 and 8 respectively.

Source files
------------

// File: rtl/rca_pipe_addsub.sv
// rtl/rca_pipe_addsub.sv - pipelined ripple-carry adder/subtractor with valid/ready handshake
// Purpose: WIDTH-bit add/subtract split into STAGES ripple slices, each slice
//   separated by a register rank holding the inter-slice carry.
// Ports:
//   clk, rst             : rising-edge clock, synchronous active-high reset
//   in_valid, in_ready   : input handshake qualifying A, B, C, SUB
//   A, B                 : operands
//   C                    : carry-in (add) / borrow-in (subtract)
//   SUB                  : 0 = add, 1 = subtract
//   out_valid, out_ready : output handshake qualifying S, cout, ovf
//   S                    : sum / difference modulo 2^WIDTH
//   cout                 : raw carry out of the MSB (1 = no borrow when subtracting)
//   ovf                  : two's-complement signed overflow
module rca_pipe_addsub #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("rca_pipe_addsub: WIDTH must be >= 1 and an exact multiple of STAGES");
  end

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Subtraction is A + ~B + ~C, so a borrow-in of 1 removes the implicit +1.
  assign b_eff   = SUB ? ~B : B;
  assign cin_eff = SUB ? ~C : C;

  // The whole pipeline freezes as one unit while the output is held.
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [WIDTH-1:0] s_i;
    logic             c_i;
    logic             v_i;
    logic [SLICE:0]   sum;
    logic [WIDTH-1:0] s_n;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             c_q;
    logic             v_q;

    if (k == 0) begin : g_head
      assign a_i = A;
      assign b_i = b_eff;
      assign s_i = '0;
      assign c_i = cin_eff;
      assign v_i = in_valid;
    end else begin : g_body
      // Operands travel whole so upper slices stay skewed with their carry;
      // finished lower result slices travel alongside so the output is aligned.
      assign a_i = g_stage[k-1].a_q;
      assign b_i = g_stage[k-1].b_q;
      assign s_i = g_stage[k-1].s_q;
      assign c_i = g_stage[k-1].c_q;
      assign v_i = g_stage[k-1].v_q;
    end

    assign sum = {1'b0, a_i[k*SLICE +: SLICE]}
               + {1'b0, b_i[k*SLICE +: SLICE]}
               + {{SLICE{1'b0}}, c_i};

    always_comb begin
      s_n                   = s_i;
      s_n[k*SLICE +: SLICE] = sum[SLICE-1:0];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
      end else if (!stall) begin
        v_q <= v_i;
        // Data registers only move with a real operation; bubbles leave them idle.
        if (v_i) begin
          a_q <= a_i;
          b_q <= b_i;
          s_q <= s_n;
          c_q <= sum[SLICE];
        end
      end
    end
  end

  assign out_valid = g_stage[LAST].v_q;
  assign S         = g_stage[LAST].s_q;
  assign cout      = g_stage[LAST].c_q;
  // Overflow uses the effective B operand, so it covers add and subtract alike.
  assign ovf       = (g_stage[LAST].a_q[WIDTH-1] == g_stage[LAST].b_q[WIDTH-1]) &&
                     (g_stage[LAST].s_q[WIDTH-1] != g_stage[LAST].a_q[WIDTH-1]);

endmodule
